rx_sampler: RTL and testbench

Front end of the UART receive path, directly upstream of the Rx bit-state FSM. It synchronises the asynchronous serial line and detects the start-bit falling edge. It generates one bit-period strobe per UART bit and supplies a majority-voted mid-bit sample. Its `start_detected` and `sampling_strobe` outputs drive the FSM's inputs of the same names; `sampled_bit` feeds the downstream data shifter and parity check.

---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/rx_synchronizer.sv | 26 ++
 rtl/rx_sampler.sv | 140 ++++++++++++++
 tb/tb_rx_sampler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive front end: phase encoding,
// the default oversampling ratio and the 2-of-3 majority vote.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        RUN    = 2'd2
    } phase_t;

    localparam int DEFAULT_CLOCKS_PER_BIT = 16;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchroniser for the asynchronous serial line. Both flops reset
// to 1 so that an idle (high) line never looks like a start edge after reset.
module rx_synchronizer (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    // Metastability filter: s1 may go metastable, s2 is the usable copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/rx_sampler.sv
// UART receive front end: synchronises serial_in, hunts for the start-bit
// falling edge, times bit periods and majority-votes three mid-bit samples.
// Optional build macro RX_FALSE_START_REJECT_EN adds a VERIFY phase that
// votes on the start bit and drops glitches before announcing a start.
module rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic serial_in,
    input  logic rx_idle,
    output logic start_detected,
    output logic sampling_strobe,
    output logic sampled_bit,
    output logic serial_sync
);

    localparam int CW  = $clog2(CLOCKS_PER_BIT);
    localparam int MID = CLOCKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_SA   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_SB   = CW'(MID);
    localparam logic [CW-1:0] CNT_SC   = CW'(MID + 1);

    if (CLOCKS_PER_BIT < 8 || (CLOCKS_PER_BIT % 2) != 0) begin : g_bad_cfg
        $error("rx_sampler: CLOCKS_PER_BIT must be even and >= 8");
    end

    logic          sync_q;
    logic          s3;
    logic          fall_edge;
    phase_t        phase;
    phase_t        phase_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic          start_q;
    logic          start_nxt;
    logic [1:0]    samp;
    logic          vote;

    rx_synchronizer u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (serial_in),
        .q     (sync_q)
    );

    assign serial_sync = sync_q;
    assign fall_edge   = s3 & ~sync_q;
    assign cnt_inc     = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    // Third sample is taken live from the synchroniser in the cnt = MID+1 cycle.
    assign vote        = majority3(samp[1], samp[0], sync_q);

    // State register: phase, bit counter, start pulse and edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase   <= HUNT;
            cnt     <= '0;
            start_q <= 1'b0;
            s3      <= 1'b1;
        end else begin
            phase   <= phase_nxt;
            cnt     <= cnt_nxt;
            start_q <= start_nxt;
            s3      <= sync_q;
        end
    end

    // Next-state logic: edge hunt, optional start verification, bit timing.
    always_comb begin
        phase_nxt = phase;
        cnt_nxt   = cnt;
        start_nxt = 1'b0;
        case (phase)
            HUNT: begin
                cnt_nxt = '0;
                if (fall_edge && rx_idle) begin
`ifdef RX_FALSE_START_REJECT_EN
                    phase_nxt = VERIFY;
`else
                    phase_nxt = RUN;
                    start_nxt = 1'b1;
`endif
                end
            end
`ifdef RX_FALSE_START_REJECT_EN
            VERIFY: begin
                cnt_nxt = cnt_inc;
                if (cnt == CNT_SC) begin
                    if (!vote) begin
                        // Genuine start bit: keep counting so strobes stay edge-aligned.
                        phase_nxt = RUN;
                        start_nxt = 1'b1;
                    end else begin
                        phase_nxt = HUNT;
                        cnt_nxt   = '0;
                    end
                end
            end
`endif
            RUN: begin
                // The start_q cycle is the first RUN cycle; the parent FSM is
                // still in IDLE then, so rx_idle is ignored for that one cycle.
                if (rx_idle && !start_q) begin
                    phase_nxt = HUNT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                phase_nxt = HUNT;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode; reset masks the pulses in the cycle it is asserted.
    always_comb begin
        start_detected  = start_q & ~reset;
        sampling_strobe = (phase == RUN) && (cnt == CNT_LAST) && !reset;
    end

    // Mid-bit sampling and majority vote, held until the next bit's vote.
    always_ff @(posedge clk) begin
        if (reset) begin
            samp        <= 2'b11;
            sampled_bit <= 1'b1;
        end else if (phase != HUNT) begin
            if (cnt == CNT_SA) samp[1] <= sync_q;
            if (cnt == CNT_SB) samp[0] <= sync_q;
            if (cnt == CNT_SC) sampled_bit <= vote;
        end
    end

endmodule

// File: tb/tb_rx_sampler.sv
// Self-checking bench for rx_sampler: frame table with a strobe scoreboard,
// plus hand sequences for the idle line, a short start pulse and reset mid-frame.
module tb_rx_sampler;

    localparam int CPB = 16;
`ifdef RX_FALSE_START_REJECT_EN
    localparam int START_LAT    = 3 + CPB / 2 + 2;
    localparam int PULSE_STARTS = 0;
`else
    localparam int START_LAT    = 3;
    localparam int PULSE_STARTS = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic serial_in;
    logic rx_idle;
    logic start_detected;
    logic sampling_strobe;
    logic sampled_bit;
    logic serial_sync;

    rx_sampler #(.CLOCKS_PER_BIT(CPB)) dut (
        .clk             (clk),
        .reset           (reset),
        .serial_in       (serial_in),
        .rx_idle         (rx_idle),
        .start_detected  (start_detected),
        .sampling_strobe (sampling_strobe),
        .sampled_bit     (sampled_bit),
        .serial_sync     (serial_sync)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   ev_start = 0;
    int   ev_strobe = 0;
    int   strobe_n = 0;
    int   fall_cyc = 0;
    logic exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Model of the downstream Rx FSM: leaves IDLE on start, returns after 11 strobes.
    logic busy;
    int   nstb;
    always @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            nstb <= 0;
        end else if (!busy) begin
            if (start_detected) begin
                busy <= 1'b1;
                nstb <= 0;
            end
        end else if (sampling_strobe) begin
            if (nstb == 10) busy <= 1'b0;
            nstb <= nstb + 1;
        end
    end
    assign rx_idle = !busy;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (!reset) begin
            if (start_detected) begin
                ev_start++;
                strobe_n = 0;
                check("start_latency", cyc - fall_cyc, START_LAT);
                check("start_strobe_exclusive", int'(sampling_strobe), 0);
            end
            if (sampling_strobe) begin
                ev_strobe++;
                strobe_n++;
                check("strobe_timing", cyc - fall_cyc, 3 + (CPB - 1) + CPB * (strobe_n - 1));
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    check("sampled_bit", int'(sampled_bit), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic drive_bit(input logic v, input int glen);
        for (int j = 0; j < CPB; j++) begin
            serial_in = (glen > 0 && j >= 9 && j < 9 + glen) ? 1'b0 : v;
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input int glen);
        logic [10:0] bits;
        bits = {1'b1, p, d, 1'b0};
        fall_cyc = cyc;
        for (int b = 0; b < 11; b++) drive_bit(bits[b], (b == 4) ? glen : 0);
        serial_in = 1'b1;
    endtask

    task automatic finish_frame(input int exp_strobes, input int strobe_base);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !rx_idle) && t < 400) begin
            tick();
            t++;
        end
        check("frame_done_in_time", int'(t < 400), 1);
        check("strobe_count", ev_strobe - strobe_base, exp_strobes);
        exp_q.delete();
        repeat (8) tick();
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         glen;
        logic [7:0] exp_data;
        logic       exp_par;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs[NV];

    initial begin
        int          base_s;
        int          base_b;
        logic [10:0] ebits;
        logic [10:0] frm;
        logic        stop;

        vecs[0] = '{8'h55, 1'b0, 0, 8'h55, 1'b0};
        vecs[1] = '{8'hFF, 1'b0, 1, 8'hFF, 1'b0};  // one low sample: outvoted
        vecs[2] = '{8'hFF, 1'b0, 2, 8'hF7, 1'b0};  // two low samples: bit 3 reads 0
        vecs[3] = '{8'h00, 1'b0, 0, 8'h00, 1'b0};
        vecs[4] = '{8'hA3, 1'b0, 0, 8'hA3, 1'b0};

        reset = 1'b1;
        serial_in = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset_start", int'(start_detected), 0);
        check("reset_strobe", int'(sampling_strobe), 0);
        check("reset_sampled_bit", int'(sampled_bit), 1);
        check("reset_serial_sync", int'(serial_sync), 1);
        tick();
        reset = 1'b0;

        // Idle line
        repeat (100) tick();
        @(negedge clk);
        check("idle_no_start", ev_start, 0);
        check("idle_no_strobe", ev_strobe, 0);
        check("idle_sampled_bit", int'(sampled_bit), 1);
        tick();

        // Frame table
        for (int i = 0; i < NV; i++) begin
            base_s = ev_start;
            base_b = ev_strobe;
            ebits = {1'b1, vecs[i].exp_par, vecs[i].exp_data, 1'b0};
            for (int b = 0; b < 11; b++) exp_q.push_back(ebits[b]);
            send_frame(vecs[i].data, vecs[i].par, vecs[i].glen);
            finish_frame(11, base_b);
            check("frame_start_count", ev_start - base_s, 1);
        end

        // Three-cycle low pulse on an idle line
        base_s = ev_start;
        base_b = ev_strobe;
        if (PULSE_STARTS != 0) begin
            for (int b = 0; b < 11; b++) exp_q.push_back(1'b1);
        end
        fall_cyc = cyc;
        serial_in = 1'b0;
        repeat (3) tick();
        serial_in = 1'b1;
        repeat (40) tick();
        finish_frame(11 * PULSE_STARTS, base_b);
        check("pulse_start_count", ev_start - base_s, PULSE_STARTS);

        // Reset asserted in the cycle of strobe 5
        base_b = ev_strobe;
        frm = {1'b1, 1'b0, 8'h05, 1'b0};
        for (int b = 0; b < 4; b++) exp_q.push_back(frm[b]);
        fall_cyc = cyc;
        stop = 1'b0;
        for (int b = 0; b < 11 && !stop; b++) begin
            for (int j = 0; j < CPB && !stop; j++) begin
                if (cyc == fall_cyc + 3 + (CPB - 1) + 4 * CPB) begin
                    stop = 1'b1;
                end else begin
                    serial_in = frm[b];
                    tick();
                end
            end
        end
        check("reached_strobe5", int'(stop), 1);
        reset = 1'b1;
        serial_in = 1'b1;
        @(negedge clk);
        check("rst_cycle_strobe", int'(sampling_strobe), 0);
        check("rst_cycle_start", int'(start_detected), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_sampled_bit", int'(sampled_bit), 1);
        check("post_rst_serial_sync", int'(serial_sync), 1);
        check("post_rst_strobe", int'(sampling_strobe), 0);
        check("post_rst_start", int'(start_detected), 0);
        check("pre_rst_strobes", ev_strobe - base_b, 4);
        check("pre_rst_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        repeat (10) tick();

        // Next frame after reset is received normally
        base_s = ev_start;
        base_b = ev_strobe;
        ebits = {1'b1, 1'b0, 8'h55, 1'b0};
        for (int b = 0; b < 11; b++) exp_q.push_back(ebits[b]);
        send_frame(8'h55, 1'b0, 0);
        finish_frame(11, base_b);
        check("post_rst_frame_start", ev_start - base_s, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

endmodule
